// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, bubble encoding, reset vector and
// the fetch-stage state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RESET,
    S_REQ,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  // Instruction fetches are word aligned, so the two low bits are cleared.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load; with neither asserted it holds.
module if_id_reg #(
  parameter logic [31:0] NOP_VAL = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);
  import riscv_pkg::*;

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // A flush keeps the old PC so the bubble still carries a sensible address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_VAL;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_VAL;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request FSM, one-entry skid buffer for stalls,
// and redirect handling that flushes the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instr,
  output logic [31:0] PC_ID,
  output logic        Valid_ID
);
  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] target;

  assign target = align_word(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // An empty fetch cycle without stall loads a bubble, which is exactly a flush.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc      = pc_q;

    case (state_q)
      S_RESET: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          if (!imem_valid) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (imem_valid) begin
          pc_d = pc_q + 32'd4;
          if (!stall) begin
            ifid_load = 1'b1;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          state_d    = S_REQ;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_instr_q;
          ifid_pc    = skid_pc_q;
          state_d    = S_REQ;
        end
      end

      S_DROP: begin
        // The old request is still in flight; its answer is thrown away.
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = target;
        end
        if (imem_valid) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

  if_id_reg #(
    .NOP_VAL (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr),
    .pc_i    (ifid_pc),
    .instr_o (Instr),
    .pc_o    (PC_ID),
    .valid_o (Valid_ID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a transaction-level reference model and a latency-controlled memory.
module tb_fetch_stage;

  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] Instr;
  logic [31:0] PC_ID;
  logic        Valid_ID;

  int checks   = 0;
  int failures = 0;

  // Reference model: booting / holding a stalled word / waiting on a stale fetch.
  bit          mBoot, mSkid, mStale;
  logic [31:0] mPc, mStaleAddr, mSkidInstr, mSkidPc;
  logic [31:0] mInstr, mPcId;
  logic        mValid;

  int memLatency = 0;
  int memWait    = 0;
  bit randLat    = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .Instr       (Instr),
    .PC_ID       (PC_ID),
    .Valid_ID    (Valid_ID)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit mReq();
    return !mBoot && !mSkid;
  endfunction

  function automatic logic [31:0] mAddr();
    return mStale ? mStaleAddr : mPc;
  endfunction

  task automatic modelReset();
    mBoot = 1; mSkid = 0; mStale = 0;
    mPc = RST_PC; mStaleAddr = 0; mSkidInstr = NOP; mSkidPc = 0;
    mInstr = NOP; mPcId = 0; mValid = 0;
    memWait = 0;
  endtask

  task automatic modelStep(input bit st, input bit rd, input logic [31:0] tgt,
                           input bit v, input logic [31:0] rdata);
    logic [31:0] dest;
    dest = tgt & ~32'h3;
    if (mBoot) begin
      mBoot = 0;
    end else if (mSkid) begin
      if (rd) begin
        mInstr = NOP; mValid = 0; mPc = dest; mSkid = 0;
      end else if (!st) begin
        mInstr = mSkidInstr; mPcId = mSkidPc; mValid = 1; mSkid = 0;
      end
    end else if (mStale) begin
      if (rd) begin
        mInstr = NOP; mValid = 0; mPc = dest;
      end
      if (v) mStale = 0;
    end else if (rd) begin
      mInstr = NOP; mValid = 0;
      if (!v) begin
        mStale = 1; mStaleAddr = mPc;
      end
      mPc = dest;
    end else if (v) begin
      if (!st) begin
        mInstr = rdata; mPcId = mPc; mValid = 1;
      end else begin
        mSkid = 1; mSkidInstr = rdata; mSkidPc = mPc;
      end
      mPc = mPc + 32'd4;
    end else if (!st) begin
      mInstr = NOP; mValid = 0;
    end
  endtask

  // Drives one cycle from a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] tgt);
    bit          reqNow, v;
    logic [31:0] rdata;
    reqNow = mReq();
    v      = reqNow && (memWait >= memLatency);
    rdata  = v ? (mAddr() ^ KEY) : 32'($urandom);
    stall = st; redirect = rd; redirect_pc = tgt;
    imem_valid = v; imem_rdata = rdata;
    modelStep(st, rd, tgt, v, rdata);
    if (v) begin
      memWait = 0;
      if (randLat) memLatency = $urandom_range(0, 2);
    end else if (reqNow) begin
      memWait++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    stall = 0; redirect = 0; redirect_pc = 0; imem_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0);
  endtask

  task automatic test_reset();
    checks++;
    if (Instr !== NOP || PC_ID !== 32'h0 || Valid_ID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ifid instr=%h pc=%h valid=%b required %h/0/0", Instr, PC_ID, Valid_ID, NOP);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_req got=%b required 0", imem_req);
    end
    rst = 1'b0;
    modelReset();
    memLatency = 0;
    applyStimulus(0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || Valid_ID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_req req=%b addr=%h valid=%b required 1/%h/0", imem_req, imem_addr, Valid_ID, RST_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0);
      checks++;
      if (Valid_ID !== 1'b1 || PC_ID !== 32'(4*i) || Instr !== (32'(4*i) ^ KEY)) begin
        failures++;
        $display("[TB] FAIL stream_ifid i=%0d got %h/%h/%b required %h/%h/1", i, Instr, PC_ID, Valid_ID, 32'(4*i) ^ KEY, 32'(4*i));
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*i + 4)) begin
        failures++;
        $display("[TB] FAIL stream_addr i=%0d got %b/%h required 1/%h", i, imem_req, imem_addr, 32'(4*i + 4));
      end
    end
  endtask

  task automatic test_stall();
    bit          stallSeq [7] = '{0, 0, 1, 1, 1, 0, 0};
    logic [31:0] pcSeq    [7] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC};
    memLatency = 0;
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(stallSeq[i], 0, 0);
      checks++;
      if (Valid_ID !== 1'b1 || PC_ID !== pcSeq[i] || Instr !== (pcSeq[i] ^ KEY)) begin
        failures++;
        $display("[TB] FAIL stall_ifid step=%0d got %h/%h/%b required %h/%h/1", i, Instr, PC_ID, Valid_ID, pcSeq[i] ^ KEY, pcSeq[i]);
      end
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] newAddr;
    bit          done;
    memLatency = 2;
    doReset();
    applyStimulus(0, 1, 32'h100);
    checks++;
    if (Valid_ID !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL drop_enter valid=%b req=%b addr=%h required 0/1/0", Valid_ID, imem_req, imem_addr);
    end
    newAddr = 32'hFFFF_FFFF;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      applyStimulus(0, 0, 0);
      if (imem_req && imem_addr != 32'h0 && newAddr == 32'hFFFF_FFFF) newAddr = imem_addr;
      checks++;
      if (Valid_ID === 1'b1 && PC_ID !== 32'h100) begin
        failures++;
        $display("[TB] FAIL drop_stale pc=%h required 100", PC_ID);
      end
      if (Valid_ID === 1'b1) done = 1;
    end
    checks++;
    if (newAddr !== 32'h100) begin
      failures++;
      $display("[TB] FAIL drop_next_addr got=%h required 100", newAddr);
    end
    checks++;
    if (!done || Instr !== (32'h100 ^ KEY)) begin
      failures++;
      $display("[TB] FAIL drop_target done=%b instr=%h required %h", done, Instr, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_redirect_hold();
    memLatency = 0;
    doReset();
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 32'h200);
    checks++;
    if (Valid_ID !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("[TB] FAIL hold_flush valid=%b req=%b addr=%h required 0/1/200", Valid_ID, imem_req, imem_addr);
    end
    applyStimulus(0, 0, 0);
    checks++;
    if (Valid_ID !== 1'b1 || PC_ID !== 32'h200 || Instr !== (32'h200 ^ KEY)) begin
      failures++;
      $display("[TB] FAIL hold_resume got %h/%h/%b required %h/200/1", Instr, PC_ID, Valid_ID, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_align_wrap();
    memLatency = 0;
    doReset();
    applyStimulus(0, 1, 32'h0000_0207);
    checks++;
    if (imem_addr !== 32'h0000_0204 || Valid_ID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL align_addr got=%h valid=%b required 00000204/0", imem_addr, Valid_ID);
    end
    applyStimulus(0, 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0);
    checks++;
    if (PC_ID !== 32'hFFFF_FFFC || Valid_ID !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wrap_addr pc_id=%h valid=%b addr=%h required fffffffc/1/0", PC_ID, Valid_ID, imem_addr);
    end
    applyStimulus(0, 0, 0);
    checks++;
    if (PC_ID !== 32'h0 || Instr !== KEY) begin
      failures++;
      $display("[TB] FAIL wrap_ifid pc_id=%h instr=%h required 0/%h", PC_ID, Instr, KEY);
    end
  endtask

  task automatic test_reset_midstream();
    memLatency = 0;
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Instr !== NOP || PC_ID !== 32'h0 || Valid_ID !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got %h/%h/%b req=%b required %h/0/0 req=0", Instr, PC_ID, Valid_ID, imem_req, NOP);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      failures++;
      $display("[TB] FAIL restart req=%b addr=%h required 1/%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    bit          st, rd;
    logic [31:0] tgt;
    memLatency = 0;
    doReset();
    randLat = 1;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      applyStimulus(st, rd, tgt);
      checks++;
      if (Instr !== mInstr || PC_ID !== mPcId || Valid_ID !== mValid) begin
        failures++;
        $display("[TB] FAIL rand_ifid cyc=%0d got %h/%h/%b required %h/%h/%b", i, Instr, PC_ID, Valid_ID, mInstr, mPcId, mValid);
      end
      checks++;
      if (imem_req !== mReq() || (mReq() && imem_addr !== mAddr())) begin
        failures++;
        $display("[TB] FAIL rand_req cyc=%0d got %b/%h required %b/%h", i, imem_req, imem_addr, mReq(), mAddr());
      end
      if (Valid_ID === 1'b1) begin
        checks++;
        if (Instr !== (PC_ID ^ KEY)) begin
          failures++;
          $display("[TB] FAIL rand_pair cyc=%0d instr=%h required %h", i, Instr, PC_ID ^ KEY);
        end
      end
    end
    randLat = 0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; redirect = 0; redirect_pc = 0;
    imem_valid = 0; imem_rdata = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_hold();
    test_align_wrap();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
